// File: rtl/inv_bank_pkg.sv
// Shared definitions for the inverting bank pipeline: mode encodings and the
// legal parameter limits.
package inv_bank_pkg;

  localparam logic [1:0] MODE_PASS   = 2'b00;
  localparam logic [1:0] MODE_INVERT = 2'b01;
  localparam logic [1:0] MODE_MASKED = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam int unsigned WIDTH_MIN  = 1;
  localparam int unsigned WIDTH_MAX  = 32;
  localparam int unsigned STAGES_MIN = 1;
  localparam int unsigned STAGES_MAX = 4;

endpackage

// File: rtl/inv_bank_pipe_if.sv
// Data, mode, mask-load and result signals of the inverting bank pipeline.
interface inv_bank_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic [1:0]       mode;
  logic             mask_sdi;
  logic             mask_shift;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             mask_loaded;

  modport master (
    output din, mode, mask_sdi, mask_shift,
    input  dout, dout_valid, mask_loaded
  );

  modport slave (
    input  din, mode, mask_sdi, mask_shift,
    output dout, dout_valid, mask_loaded
  );
endinterface

// File: rtl/inv_mask_loader.sv
// Serial mask loader: shifts bits into a shadow register and commits the
// completed word to active_mask after WIDTH shifts.
module inv_mask_loader #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mask_sdi,
  input  logic             mask_shift,
  output logic [WIDTH-1:0] active_mask,
  output logic             mask_loaded
);
  import inv_bank_pkg::*;

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shadow_q, shadow_d, shifted;
  logic [WIDTH-1:0] active_mask_q, active_mask_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             mask_loaded_q, mask_loaded_d;

  // New bits enter at the MSB so the first bit ends up in bit 0.
  if (WIDTH == 1) begin : g_shift_one
    assign shifted = mask_sdi;
  end else begin : g_shift_many
    assign shifted = {mask_sdi, shadow_q[WIDTH-1:1]};
  end

  always_comb begin
    shadow_d      = shadow_q;
    cnt_d         = cnt_q;
    active_mask_d = active_mask_q;
    mask_loaded_d = 1'b0;
    if (mask_shift) begin
      shadow_d = shifted;
      if (cnt_q == CntW'(WIDTH - 1)) begin
        cnt_d         = '0;
        active_mask_d = shifted;
        mask_loaded_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q      <= '0;
      cnt_q         <= '0;
      active_mask_q <= '1;
      mask_loaded_q <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      cnt_q         <= cnt_d;
      active_mask_q <= active_mask_d;
      mask_loaded_q <= mask_loaded_d;
    end
  end

  assign active_mask = active_mask_q;
  assign mask_loaded = mask_loaded_q;

endmodule

// File: rtl/inv_bank_pipe.sv
// Pass / invert / mask / hold datapath followed by STAGES output registers,
// with a serially loaded XOR mask.
module inv_bank_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 1
) (
  input  logic            clk,
  input  logic            reset,
  inv_bank_pipe_if.slave  bus
);
  import inv_bank_pkg::*;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("inv_bank_pipe: WIDTH out of range");
  end
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("inv_bank_pipe: STAGES out of range");
  end

  logic [WIDTH-1:0]  stage_q [STAGES];
  logic [WIDTH-1:0]  stage_d [STAGES];
  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  active_mask;

  inv_mask_loader #(
    .WIDTH(WIDTH)
  ) u_mask_loader (
    .clk         (clk),
    .reset       (reset),
    .mask_sdi    (bus.mask_sdi),
    .mask_shift  (bus.mask_shift),
    .active_mask (active_mask),
    .mask_loaded (bus.mask_loaded)
  );

  always_comb begin
    unique case (bus.mode)
      MODE_PASS:   stage_d[0] = bus.din;
      MODE_INVERT: stage_d[0] = ~bus.din;
      MODE_MASKED: stage_d[0] = bus.din ^ active_mask;
      default:     stage_d[0] = stage_q[0];
    endcase
    // Later stages shift regardless of mode, so HOLD only freezes stage 0.
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    valid_d = (valid_q << 1) | STAGES'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
      valid_q <= valid_d;
    end
  end

  assign bus.dout       = stage_q[STAGES-1];
  assign bus.dout_valid = valid_q[STAGES-1];

endmodule

// File: tb/tb_inv_bank_pipe.sv
// Bench for inv_bank_pipe: three instances (STAGES 1, 2, 3) share one stimulus
// stream; a reference model feeds per-instance expected-output queues.
module tb_inv_bank_pipe;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  inv_bank_pipe_if #(.WIDTH(8)) bus1 ();
  inv_bank_pipe_if #(.WIDTH(8)) bus2 ();
  inv_bank_pipe_if #(.WIDTH(8)) bus3 ();

  inv_bank_pipe #(.WIDTH(8), .STAGES(1)) dut1 (.clk(clk), .reset(rst), .bus(bus1.slave));
  inv_bank_pipe #(.WIDTH(8), .STAGES(2)) dut2 (.clk(clk), .reset(rst), .bus(bus2.slave));
  inv_bank_pipe #(.WIDTH(8), .STAGES(3)) dut3 (.clk(clk), .reset(rst), .bus(bus3.slave));

  // Reference model state
  logic [7:0] m_s0, m_shadow, m_active;
  int         m_cnt;
  logic       m_pulse;
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] q3[$];

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] md, input logic [7:0] d,
                       input logic sh, input logic sdi);
    logic [7:0] e;
    rst = r;
    bus1.mode = md; bus1.din = d; bus1.mask_shift = sh; bus1.mask_sdi = sdi;
    bus2.mode = md; bus2.din = d; bus2.mask_shift = sh; bus2.mask_sdi = sdi;
    bus3.mode = md; bus3.din = d; bus3.mask_shift = sh; bus3.mask_sdi = sdi;
    @(posedge clk);
    if (r) begin
      m_s0 = 8'h00; m_shadow = 8'h00; m_active = 8'hFF; m_cnt = 0; m_pulse = 1'b0;
      q1.delete(); q2.delete(); q3.delete();
    end else begin
      case (md)
        2'b00: m_s0 = d;
        2'b01: m_s0 = ~d;
        2'b10: m_s0 = d ^ m_active;
        default: m_s0 = m_s0;
      endcase
      m_pulse = 1'b0;
      if (sh) begin
        m_shadow = {sdi, m_shadow[7:1]};
        m_cnt++;
        if (m_cnt == 8) begin
          m_cnt = 0;
          m_active = m_shadow;
          m_pulse = 1'b1;
        end
      end
      q1.push_back(m_s0); q2.push_back(m_s0); q3.push_back(m_s0);
    end
    #1;
    cmp("loaded1", bus1.mask_loaded, m_pulse);
    cmp("loaded2", bus2.mask_loaded, m_pulse);
    cmp("loaded3", bus3.mask_loaded, m_pulse);
    if (q1.size() == 1) begin
      e = q1.pop_front();
      cmp("dout1", bus1.dout, e); cmp("valid1", bus1.dout_valid, 1);
    end else begin
      cmp("dout1_empty", bus1.dout, 0); cmp("valid1_low", bus1.dout_valid, 0);
    end
    if (q2.size() == 2) begin
      e = q2.pop_front();
      cmp("dout2", bus2.dout, e); cmp("valid2", bus2.dout_valid, 1);
    end else begin
      cmp("dout2_empty", bus2.dout, 0); cmp("valid2_low", bus2.dout_valid, 0);
    end
    if (q3.size() == 3) begin
      e = q3.pop_front();
      cmp("dout3", bus3.dout, e); cmp("valid3", bus3.dout_valid, 1);
    end else begin
      cmp("dout3_empty", bus3.dout, 0); cmp("valid3_low", bus3.dout_valid, 0);
    end
  endtask

  initial begin
    logic [7:0] bits;

    // Reset with live inputs, then release: PASS of 3C one cycle later
    drive(1, 2'b00, 8'h3C, 0, 0);
    drive(1, 2'b00, 8'h3C, 0, 0);
    cmp("rst_dout1", bus1.dout, 8'h00);
    drive(0, 2'b00, 8'h3C, 0, 0);
    cmp("pass_3c", bus1.dout, 8'h3C);

    // INVERT of A5 with 2-stage latency and valid timing
    drive(1, 2'b01, 8'hA5, 0, 0);
    drive(0, 2'b01, 8'hA5, 0, 0);
    cmp("inv_valid_edge1", bus2.dout_valid, 0);
    drive(0, 2'b01, 8'hA5, 0, 0);
    cmp("inv_5a", bus2.dout, 8'h5A);
    cmp("inv_valid_edge2", bus2.dout_valid, 1);

    // MASKED before any load behaves like INVERT
    drive(1, 2'b10, 8'h0F, 0, 0);
    drive(0, 2'b10, 8'h0F, 0, 0);
    cmp("mask_default", bus1.dout, 8'hF0);

    // Load 1,1,1,1,0,0,0,0 with two gaps, din=00 held through the commit edge
    bits = 8'h0F;
    for (int i = 0; i < 4; i++) drive(0, 2'b10, 8'h00, 1, bits[i]);
    drive(0, 2'b10, 8'h00, 0, 1);
    drive(0, 2'b10, 8'h00, 1, bits[4]);
    drive(0, 2'b10, 8'h00, 1, bits[5]);
    drive(0, 2'b10, 8'h00, 0, 1);
    drive(0, 2'b10, 8'h00, 1, bits[6]);
    drive(0, 2'b10, 8'h00, 1, bits[7]);
    cmp("commit_old_mask", bus1.dout, 8'hFF);
    cmp("commit_pulse", bus1.mask_loaded, 1);
    drive(0, 2'b10, 8'hFF, 0, 0);
    cmp("new_mask_ff", bus1.dout, 8'hF0);
    cmp("pulse_once", bus1.mask_loaded, 0);

    // Settle at 11 then HOLD while din toggles
    for (int i = 0; i < 4; i++) drive(0, 2'b00, 8'h11, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 2'b11, (i % 2) ? 8'hAA : 8'h55, 0, 0);
    cmp("hold_11", bus3.dout, 8'h11);
    cmp("hold_valid", bus3.dout_valid, 1);

    // Partial load discarded by reset, then full load of 81
    for (int i = 0; i < 5; i++) drive(0, 2'b00, 8'h00, 1, 1'(i % 2));
    drive(1, 2'b00, 8'h00, 0, 0);
    bits = 8'h81;
    for (int i = 0; i < 8; i++) drive(0, 2'b00, 8'h00, 1, bits[i]);
    drive(0, 2'b10, 8'h00, 0, 0);
    cmp("mask_81", bus1.dout, 8'h81);

    // Randomised traffic against the model
    for (int i = 0; i < 60; i++) begin
      drive(($urandom_range(0, 24) == 0), 2'($urandom_range(0, 3)), 8'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
